// File: rtl/pin_test_pkg.sv
// rtl/pin_test_pkg.sv - shared types and pattern helpers for the pin test sequencer
//
// Purpose: mode encodings, FSM state type, and the pattern / last-step
// functions used by pin_test_sequencer.
// Ports: none (package).
package pin_test_pkg;

    // pattern() builds its result in a fixed-width vector; callers cast it
    // down to their own WIDTH, so WIDTH must not exceed this.
    localparam int MAX_WIDTH = 256;

    localparam logic [1:0] MODE_WALK1 = 2'd0;
    localparam logic [1:0] MODE_WALK0 = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_ALLON = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    function automatic logic [MAX_WIDTH-1:0] pattern(
        input logic [1:0] mode,
        input int         step,
        input int         width
    );
        logic [MAX_WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                case (mode)
                    MODE_WALK1: p[i] = (i == step);
                    MODE_WALK0: p[i] = (i != step);
                    // Step 0 lights the even bits, step 1 the odd bits.
                    MODE_CHECK: p[i] = ((i % 2) == 0) ^ (step != 0);
                    default:    p[i] = 1'b1;
                endcase
            end
        end
        return p;
    endfunction

    function automatic int last_step(
        input logic [1:0] mode,
        input int         width
    );
        int r;
        case (mode)
            MODE_WALK1: r = width - 1;
            MODE_WALK0: r = width - 1;
            MODE_CHECK: r = 1;
            default:    r = 0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pin_test_sequencer_debounce.sv
// rtl/pin_test_sequencer_debounce.sv - push-button synchroniser and debouncer
//
// Purpose: synchronise the raw active-low button, accept a new level only
// after it has been stable for DEBOUNCE_CYCLES, and pulse on each accepted
// press (stable 1->0). Releases produce no pulse.
// Ports:
//   i_clk    - system clock
//   i_reset  - synchronous active-high reset
//   i_button - raw button, active-low, asynchronous
//   o_press  - one-cycle pulse per debounced press
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_button,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_stable) begin
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                    // Only the released->pressed transition is an event.
                    r_press  <= r_stable & ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/pin_test_sequencer.sv
// rtl/pin_test_sequencer.sv - production pin-test pattern sequencer
//
// Purpose: on a debounced press, step the pin bus through WALK1, WALK0,
// CHECK and ALLON patterns, each driven for ON_CYCLES then followed by an
// OFF_CYCLES all-low gap. Another press aborts to idle. The pass LED toggles
// at the end of each mode.
// Ports:
//   i_clk       - system clock
//   i_reset     - synchronous active-high reset
//   i_button    - raw button, active-low, asynchronous
//   o_pin_out   - pattern bus to the pins
//   o_pin_valid - high while a pattern is driven
//   o_mode      - current pattern mode
//   o_pass_done - one-cycle pulse at the end of each mode pass
//   o_led_green - pass indicator
//   o_led_red   - inverse of o_led_green
module pin_test_sequencer
    import pin_test_pkg::*;
#(
    parameter int WIDTH           = 80,
    parameter int ON_CYCLES       = 25000,
    parameter int OFF_CYCLES      = 25000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_button,
    output logic [WIDTH-1:0] o_pin_out,
    output logic             o_pin_valid,
    output logic [1:0]       o_mode,
    output logic             o_pass_done,
    output logic             o_led_green,
    output logic             o_led_red
);

    localparam int SW     = $clog2(WIDTH);
    localparam int MAXC   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t           r_state;
    logic [SW-1:0]    r_step;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_pin_out;
    logic             r_pin_valid;
    logic [1:0]       r_mode;
    logic             r_pass_done;
    logic             r_led_green;

    logic             w_press;
    logic             w_is_last;
    logic [1:0]       w_nxt_mode;
    logic [SW-1:0]    w_nxt_step;
    logic [WIDTH-1:0] w_nxt_pat;
    logic [WIDTH-1:0] w_start_pat;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_button(i_button),
        .o_press (w_press)
    );

    // Where the run goes after the current OFF window expires.
    always_comb begin
        w_is_last   = (int'(r_step) == last_step(r_mode, WIDTH));
        w_nxt_mode  = w_is_last ? r_mode + 2'd1 : r_mode;
        w_nxt_step  = w_is_last ? '0 : r_step + SW'(1);
        w_nxt_pat   = WIDTH'(pattern(w_nxt_mode, int'(w_nxt_step), WIDTH));
        w_start_pat = WIDTH'(pattern(r_mode, 0, WIDTH));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_step      <= '0;
            r_cnt       <= '0;
            r_pin_out   <= '0;
            r_pin_valid <= 1'b0;
            r_mode      <= MODE_WALK1;
            r_pass_done <= 1'b0;
            r_led_green <= 1'b0;
        end else begin
            r_pass_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pin_out   <= '0;
                    r_pin_valid <= 1'b0;
                    r_step      <= '0;
                    r_cnt       <= '0;
                    if (w_press) begin
                        r_state     <= ON;
                        r_pin_out   <= w_start_pat;
                        r_pin_valid <= 1'b1;
                    end
                end
                ON: begin
                    if (w_press) begin
                        r_state     <= IDLE;
                        r_step      <= '0;
                        r_cnt       <= '0;
                        r_pin_out   <= '0;
                        r_pin_valid <= 1'b0;
                    end else if (r_cnt == CNT_W'(ON_CYCLES - 1)) begin
                        r_state     <= OFF;
                        r_cnt       <= '0;
                        r_pin_out   <= '0;
                        r_pin_valid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                OFF: begin
                    // A press wins over window expiry: no pass credit.
                    if (w_press) begin
                        r_state <= IDLE;
                        r_step  <= '0;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_W'(OFF_CYCLES - 1)) begin
                        r_state     <= ON;
                        r_cnt       <= '0;
                        r_step      <= w_nxt_step;
                        r_mode      <= w_nxt_mode;
                        r_pin_out   <= w_nxt_pat;
                        r_pin_valid <= 1'b1;
                        if (w_is_last) begin
                            r_pass_done <= 1'b1;
                            r_led_green <= ~r_led_green;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_pin_out   = r_pin_out;
    assign o_pin_valid = r_pin_valid;
    assign o_mode      = r_mode;
    assign o_pass_done = r_pass_done;
    assign o_led_green = r_led_green;
    assign o_led_red   = ~r_led_green;

endmodule
